// File: rtl/axil_pkg.sv
// Shared AXI4-Lite response codes and elaboration-time helpers for the memory slave.
package axil_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axil_resp_e;

  function automatic int unsigned clog2(input longint unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/axil_mem_core.sv
// Simple dual-port RAM: one byte-enabled write port, one registered read port (read-before-write).
module axil_mem_core
  import axil_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned DEPTH      = 1024,
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  localparam int unsigned IDX_W      = (DEPTH > 1) ? clog2(DEPTH) : 1
)(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [STRB_WIDTH-1:0] wstrb_i,
  input  logic                  re_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage is deliberately not reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
        if (wstrb_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axil_mem_slave.sv
// AXI4-Lite memory slave: independent AW/W holding regs, commit logic, response regs and range checks.
module axil_mem_slave
  import axil_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned ADDR_WIDTH = 32,
  parameter  int unsigned MEM_BYTES  = 4096,
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
)(
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  WVALID,
  output logic                  WREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [STRB_WIDTH-1:0] WSTRB,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic [1:0]            BRESP,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP
);

  localparam int unsigned ADDR_LSB = clog2(STRB_WIDTH);
  localparam int unsigned MEM_AB   = clog2(MEM_BYTES);
  localparam int unsigned DEPTH    = MEM_BYTES / STRB_WIDTH;
  localparam int unsigned IDX_W    = (DEPTH > 1) ? clog2(DEPTH) : 1;

  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_data_width
    $error("axil_mem_slave: DATA_WIDTH must be 32 or 64");
  end
  if (MEM_BYTES != (1 << MEM_AB) || MEM_BYTES < STRB_WIDTH) begin : g_bad_mem_bytes
    $error("axil_mem_slave: MEM_BYTES must be a power of two >= DATA_WIDTH/8");
  end

  logic                  aw_full_q, aw_full_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                  w_full_q,  w_full_d;
  logic [DATA_WIDTH-1:0] w_data_q,  w_data_d;
  logic [STRB_WIDTH-1:0] w_strb_q,  w_strb_d;
  logic                  bvalid_q,  bvalid_d;
  axil_resp_e            bresp_q,   bresp_d;
  logic                  rvalid_q,  rvalid_d;
  axil_resp_e            rresp_q,   rresp_d;

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic                  wr_oob, rd_oob, mem_we, mem_re;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic [DATA_WIDTH-1:0] core_rdata;

  assign AWREADY = !aw_full_q;
  assign WREADY  = !w_full_q;
  assign ARREADY = !rvalid_q || RREADY;

  always_comb begin
    aw_hs   = AWVALID && !aw_full_q;
    w_hs    = WVALID  && !w_full_q;
    ar_hs   = ARVALID && ARREADY;

    // A live handshake bypasses its empty holding reg so AW+W can commit in the same cycle.
    wr_addr = aw_full_q ? aw_addr_q : AWADDR;
    wr_data = w_full_q  ? w_data_q  : WDATA;
    wr_strb = w_full_q  ? w_strb_q  : WSTRB;
    commit  = (aw_full_q || aw_hs) && (w_full_q || w_hs) && (!bvalid_q || BREADY);

    wr_oob  = (wr_addr >> MEM_AB) != '0;
    rd_oob  = (ARADDR  >> MEM_AB) != '0;
    mem_we  = commit && !wr_oob && !ARESET;
    mem_re  = ar_hs && !rd_oob;

    aw_full_d = commit ? 1'b0 : (aw_full_q || aw_hs);
    aw_addr_d = aw_hs ? AWADDR : aw_addr_q;
    w_full_d  = commit ? 1'b0 : (w_full_q || w_hs);
    w_data_d  = w_hs ? WDATA : w_data_q;
    w_strb_d  = w_hs ? WSTRB : w_strb_q;

    bvalid_d  = commit || (bvalid_q && !BREADY);
    bresp_d   = bresp_q;
    if (commit) bresp_d = wr_oob ? RESP_DECERR : RESP_OKAY;

    rvalid_d  = ar_hs || (rvalid_q && !RREADY);
    rresp_d   = rresp_q;
    if (ar_hs) rresp_d = rd_oob ? RESP_DECERR : RESP_OKAY;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
    end else begin
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
    end
  end

  axil_mem_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_core (
    .clk_i   (ACLK),
    .rst_i   (ARESET),
    .we_i    (mem_we),
    .waddr_i (IDX_W'(wr_addr >> ADDR_LSB)),
    .wdata_i (wr_data),
    .wstrb_i (wr_strb),
    .re_i    (mem_re),
    .raddr_i (IDX_W'(ARADDR >> ADDR_LSB)),
    .rdata_o (core_rdata)
  );

  assign BVALID = bvalid_q;
  assign BRESP  = bresp_q;
  assign RVALID = rvalid_q;
  assign RRESP  = rresp_q;
  // The RAM read register is left untouched on a DECERR read; the data is masked here instead.
  assign RDATA  = (rresp_q == RESP_DECERR) ? '0 : core_rdata;

endmodule

// File: tb/tb_axil_mem_slave.sv
// Scoreboard bench for axil_mem_slave: 32-bit instance with a reference memory model, plus a 64-bit instance.
module tb_axil_mem_slave;
  import axil_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // 32-bit instance
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  // 64-bit instance
  logic        d64_awvalid, d64_awready, d64_wvalid, d64_wready, d64_bvalid, d64_bready;
  logic        d64_arvalid, d64_arready, d64_rvalid, d64_rready;
  logic [31:0] d64_awaddr, d64_araddr;
  logic [63:0] d64_wdata, d64_rdata;
  logic [7:0]  d64_wstrb;
  logic [1:0]  d64_bresp, d64_rresp;

  axil_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_BYTES(4096)) u_dut32 (
    .ACLK(clk), .ARESET(rst),
    .AWVALID(awvalid), .AWREADY(awready), .AWADDR(awaddr),
    .WVALID(wvalid), .WREADY(wready), .WDATA(wdata), .WSTRB(wstrb),
    .BVALID(bvalid), .BREADY(bready), .BRESP(bresp),
    .ARVALID(arvalid), .ARREADY(arready), .ARADDR(araddr),
    .RVALID(rvalid), .RREADY(rready), .RDATA(rdata), .RRESP(rresp)
  );

  axil_mem_slave #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .MEM_BYTES(4096)) u_dut64 (
    .ACLK(clk), .ARESET(rst),
    .AWVALID(d64_awvalid), .AWREADY(d64_awready), .AWADDR(d64_awaddr),
    .WVALID(d64_wvalid), .WREADY(d64_wready), .WDATA(d64_wdata), .WSTRB(d64_wstrb),
    .BVALID(d64_bvalid), .BREADY(d64_bready), .BRESP(d64_bresp),
    .ARVALID(d64_arvalid), .ARREADY(d64_arready), .ARADDR(d64_araddr),
    .RVALID(d64_rvalid), .RREADY(d64_rready), .RDATA(d64_rdata), .RRESP(d64_rresp)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [1:0]  exp_b [$];
  rexp_t       exp_r [$];
  logic [31:0] model [int unsigned];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mdl_rd(input logic [31:0] a);
    if (a >= 32'd4096) return '0;
    if (model.exists(int'(a[11:2]))) return model[int'(a[11:2])];
    return '0;
  endfunction

  function automatic void mdl_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    if (a >= 32'd4096) return;
    w = mdl_rd(a);
    for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
    model[int'(a[11:2])] = w;
  endfunction

  // Response monitor: pops the scoreboard whenever a response handshake is about to happen.
  rexp_t mon_e;
  always @(negedge clk) begin
    if (!rst && bvalid && bready) begin
      if (exp_b.size() == 0) check("b_unexpected", 1, 0);
      else check("bresp", bresp, exp_b.pop_front());
    end
    if (!rst && rvalid && rready) begin
      if (exp_r.size() == 0) check("r_unexpected", 1, 0);
      else begin
        mon_e = exp_r.pop_front();
        check("rdata", rdata, mon_e.data);
        check("rresp", rresp, mon_e.resp);
      end
    end
  end

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int unsigned aw_lag);
    bit aw_done, w_done, aw_hs, w_hs;
    int unsigned cyc;
    aw_done = 0; w_done = 0; cyc = 0;
    exp_b.push_back((a >= 32'd4096) ? RESP_DECERR : RESP_OKAY);
    mdl_wr(a, d, s);
    wvalid = 1'b1; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && cyc < 50) begin
      if (!aw_done && cyc >= aw_lag) begin awvalid = 1'b1; awaddr = a; end
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hs) begin aw_done = 1; awvalid = 1'b0; end
      if (w_hs) begin
        w_done = 1; wvalid = 1'b0;
        if (!aw_done) check("w_hold_wready", wready, 0);
      end
      cyc++;
    end
    check("wr_hs_done", {aw_done, w_done}, 2'b11);
    check("bvalid_lat", bvalid, 1);
  endtask

  task automatic axi_read(input logic [31:0] a);
    bit hs;
    int unsigned cyc;
    rexp_t e;
    hs = 0; cyc = 0;
    e.data = mdl_rd(a);
    e.resp = (a >= 32'd4096) ? RESP_DECERR : RESP_OKAY;
    exp_r.push_back(e);
    arvalid = 1'b1; araddr = a;
    while (!hs && cyc < 50) begin
      @(negedge clk);
      hs = arvalid && arready;
      @(posedge clk); #1;
      cyc++;
    end
    arvalid = 1'b0;
    check("rd_hs_done", hs, 1);
    check("rvalid_lat", rvalid, 1);
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 100) begin
      @(posedge clk); n++;
    end
    check("drain_b", exp_b.size(), 0);
    check("drain_r", exp_r.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    awvalid = 0; awaddr = '0; wvalid = 0; wdata = '0; wstrb = '0; bready = 1;
    arvalid = 0; araddr = '0; rready = 1;
    d64_awvalid = 0; d64_awaddr = '0; d64_wvalid = 0; d64_wdata = '0; d64_wstrb = '0; d64_bready = 1;
    d64_arvalid = 0; d64_araddr = '0; d64_rready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_bvalid", bvalid, 0);   check("rst_rvalid", rvalid, 0);
    check("rst_bresp", bresp, 0);     check("rst_rresp", rresp, 0);
    check("rst_rdata", rdata, 0);     check("rst_awready", awready, 1);
    check("rst_wready", wready, 1);   check("rst_arready", arready, 1);
    @(posedge clk); #1;

    // Basic write then read
    axi_write(32'h010, 32'hDEADBEEF, 4'hF, 0);
    axi_read(32'h010);
    drain();

    // W leads AW by three cycles
    axi_write(32'h030, 32'hCAFEF00D, 4'hF, 3);
    axi_read(32'h030);
    drain();

    // Partial strobes, and WSTRB=0 leaves memory untouched
    axi_write(32'h020, 32'hAAAAAAAA, 4'hF, 0);
    axi_write(32'h020, 32'h11223344, 4'b0101, 0);
    axi_read(32'h020);
    check("strb_model", mdl_rd(32'h020), 32'hAA22AA44);
    axi_write(32'h010, 32'h00000000, 4'h0, 0);
    axi_read(32'h010);
    drain();

    // Out-of-range accesses alias onto word 0 if the range check is missing
    axi_write(32'h000, 32'h12345678, 4'hF, 0);
    axi_write(32'h1000, 32'h99999999, 4'hF, 0);
    axi_read(32'h1000);
    axi_read(32'h000);
    drain();

    // Backpressure on both response channels with two writes and two reads queued
    bready = 1'b0; rready = 1'b0;
    fork
      begin
        axi_write(32'h100, 32'h0BADF00D, 4'hF, 0);
        axi_write(32'h2000, 32'h77777777, 4'hF, 0);
      end
      begin
        axi_read(32'h010);
        axi_read(32'h020);
      end
      begin
        repeat (3) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("bp_bvalid", bvalid, 1);   check("bp_bresp", bresp, RESP_OKAY);
          check("bp_rvalid", rvalid, 1);   check("bp_rdata", rdata, 32'hDEADBEEF);
          check("bp_awready", awready, 0); check("bp_wready", wready, 0);
          check("bp_arready", arready, 0);
        end
        @(posedge clk); #1;
        bready = 1'b1; rready = 1'b1;
      end
    join
    drain();

    // Reset drops a pending AW hold and suppresses a write committing in the reset cycle
    axi_write(32'h040, 32'h5555AAAA, 4'hF, 0);
    drain();
    awvalid = 1'b1; awaddr = 32'h040;
    @(posedge clk); #1;
    awvalid = 1'b0;
    check("aw_hold_full", awready, 0);
    rst = 1'b1; wvalid = 1'b1; wdata = 32'h0; wstrb = 4'hF;
    @(posedge clk); #1;
    rst = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("mid_rst_awready", awready, 1);
    check("mid_rst_wready", wready, 1);
    check("mid_rst_bvalid", bvalid, 0);
    @(posedge clk); #1;
    axi_read(32'h040);
    drain();

    // 64-bit instance: same-cycle write and read of one word returns the old data
    d64_awvalid = 1'b1; d64_awaddr = 32'h008;
    d64_wvalid = 1'b1; d64_wdata = 64'h0123456789ABCDEF; d64_wstrb = 8'hFF;
    @(negedge clk);
    check("d64_awready", d64_awready, 1);
    check("d64_wready", d64_wready, 1);
    @(posedge clk); #1;
    d64_awvalid = 1'b0; d64_wvalid = 1'b0;
    check("d64_bvalid", d64_bvalid, 1);
    check("d64_bresp", d64_bresp, RESP_OKAY);
    d64_awvalid = 1'b1; d64_wvalid = 1'b1; d64_wdata = 64'hFEDCBA9876543210;
    d64_arvalid = 1'b1; d64_araddr = 32'h008;
    @(negedge clk);
    check("d64_arready", d64_arready, 1);
    @(posedge clk); #1;
    d64_awvalid = 1'b0; d64_wvalid = 1'b0; d64_arvalid = 1'b0;
    check("d64_rvalid", d64_rvalid, 1);
    check("d64_rdata_old", d64_rdata, 64'h0123456789ABCDEF);
    check("d64_bvalid2", d64_bvalid, 1);
    d64_arvalid = 1'b1;
    @(posedge clk); #1;
    d64_arvalid = 1'b0;
    check("d64_rdata_new", d64_rdata, 64'hFEDCBA9876543210);
    check("d64_rresp", d64_rresp, RESP_OKAY);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
